riscv_hazard_ctrl: RTL

RISCV_HAZARD_CTRL -- requirements
Module: riscv_hazard_ctrl

---
 rtl/riscv_hazard_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl
//   Pipeline hazard controller for a five-stage RISC-V core. It generates stage
//   hold and clear controls for load-use hazards, taken branches, multi-cycle
//   multiply/divide operations, data-memory wait states and trap redirects.
//
//   Optional feature macro: RISCV_MDU_STALL_EN
//     defined   - the MDU stall state and its latency counter are active.
//     undefined - i_mdu_start is ignored, the MDU state is never entered and
//                 MDU_LATENCY has no effect.
//
// Parameters
//   MDU_LATENCY   cycles a multiply/divide occupies EX (2..15)
//   TRAP_BUBBLES  cycles IF is held after a trap redirect (1..3)
//
// Ports
//   i_clk          clock, rising edge
//   i_rstn         asynchronous active-low reset
//   i_ld_use_hzd   ID source register matches a load destination in EX
//   i_br_taken     EX resolved a taken branch/jump (pulse)
//   i_mdu_start    EX issues a multiply/divide (pulse)
//   i_dmem_req     MEM issues a data access
//   i_dmem_ack     data memory completes the access
//   i_trap         exception or interrupt taken (pulse)
//   o_hold_*       stage register hold (1 = keep contents)
//   o_clr_*        synchronous stage register clear to bubble
//   o_state        current state (RUN=0, MDU=1, DMEM=2, TRAP=3)
//
// state | meaning
// ------+----------------------------------------------------------------
// RUN   | normal flow; load-use, branch and DMEM-wait handled per cycle
// MDU   | multiply/divide in EX; front end and EX held, MEM fed bubbles
// DMEM  | waiting for data memory acknowledge; whole pipe held
// TRAP  | trap redirect; IF held, ID/EX/MEM flushed for TRAP_BUBBLES cycles

module riscv_hazard_ctrl #(
   parameter int unsigned MDU_LATENCY  = 4,
   parameter int unsigned TRAP_BUBBLES = 2
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_ld_use_hzd,
   input  logic       i_br_taken,
   input  logic       i_mdu_start,
   input  logic       i_dmem_req,
   input  logic       i_dmem_ack,
   input  logic       i_trap,
   output logic       o_hold_if,
   output logic       o_hold_id,
   output logic       o_hold_ex,
   output logic       o_hold_mem,
   output logic       o_clr_id,
   output logic       o_clr_ex,
   output logic       o_clr_mem,
   output logic [1:0] o_state
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_MDU  = 2'd1;
   localparam logic [1:0] ST_DMEM = 2'd2;
   localparam logic [1:0] ST_TRAP = 2'd3;

`ifdef RISCV_MDU_STALL_EN
   localparam logic MDU_EN = 1'b1;
`else
   localparam logic MDU_EN = 1'b0;
`endif

   // Counters hold "cycles left minus one" so the exit happens on terminal count 0.
   localparam logic [3:0] MDU_LOAD  = 4'(MDU_LATENCY - 1);
   localparam logic [3:0] TRAP_LOAD = 4'(TRAP_BUBBLES - 1);

   logic [1:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       dmem_wait;
   logic       mdu_go;

   assign dmem_wait = i_dmem_req & ~i_dmem_ack;
   assign mdu_go    = i_mdu_start & MDU_EN;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (i_trap) begin
         state_nxt = ST_TRAP;
         cnt_nxt   = TRAP_LOAD;
      end else begin
         case (state)
            ST_RUN: begin
               if (dmem_wait) begin
                  state_nxt = ST_DMEM;
               end else if (mdu_go) begin
                  state_nxt = ST_MDU;
                  cnt_nxt   = MDU_LOAD;
               end
            end
            ST_MDU, ST_TRAP: begin
               if (cnt == 4'd0) state_nxt = ST_RUN;
               else             cnt_nxt   = cnt - 4'd1;
            end
            ST_DMEM: begin
               // A multiply/divide issue here is dropped; EX is held and re-issues.
               if (i_dmem_ack) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= ST_RUN;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // In RUN the controls follow the current-cycle events in priority order:
   // trap > DMEM wait > taken branch > load-use. The reset term keeps every
   // control low while reset is asserted, whatever the inputs are doing.
   always_comb begin
      o_hold_if  = 1'b0;
      o_hold_id  = 1'b0;
      o_hold_ex  = 1'b0;
      o_hold_mem = 1'b0;
      o_clr_id   = 1'b0;
      o_clr_ex   = 1'b0;
      o_clr_mem  = 1'b0;
      if (i_rstn) begin
         case (state)
            ST_RUN: begin
               if (i_trap) begin
                  o_hold_if = 1'b1;
                  o_clr_id  = 1'b1;
                  o_clr_ex  = 1'b1;
                  o_clr_mem = 1'b1;
               end else if (dmem_wait) begin
                  o_hold_if  = 1'b1;
                  o_hold_id  = 1'b1;
                  o_hold_ex  = 1'b1;
                  o_hold_mem = 1'b1;
               end else if (i_br_taken) begin
                  o_clr_id = 1'b1;
                  o_clr_ex = 1'b1;
               end else if (i_ld_use_hzd) begin
                  o_hold_if = 1'b1;
                  o_hold_id = 1'b1;
                  o_clr_ex  = 1'b1;
               end
            end
            ST_MDU: begin
               o_hold_if = 1'b1;
               o_hold_id = 1'b1;
               o_hold_ex = 1'b1;
               o_clr_mem = 1'b1;
            end
            ST_DMEM: begin
               o_hold_if  = 1'b1;
               o_hold_id  = 1'b1;
               o_hold_ex  = 1'b1;
               o_hold_mem = 1'b1;
            end
            ST_TRAP: begin
               o_hold_if = 1'b1;
               o_clr_id  = 1'b1;
               o_clr_ex  = 1'b1;
               o_clr_mem = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_state = state;

endmodule
